// File: rtl/regfile_sb_pkg.sv
// Shared sizing helpers and types for the integer register file and its scoreboard.
package regfile_sb_pkg;

  // Index width for a register count; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

  localparam int unsigned ZERO_IDX = 0;

  localparam int unsigned DEF_XLEN = 32;
  localparam int unsigned DEF_NREG = 32;

  typedef logic [DEF_XLEN-1:0]              word_t;
  typedef logic [idx_width(DEF_NREG)-1:0]   idx_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the register file: reads, writeback, issue and flush.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NUM_RD = 2
) ();

  localparam int unsigned AW = idx_width(NREG);

  logic                   wb_en;
  logic [AW-1:0]          wb_index;
  logic [XLEN-1:0]        wb_data;
  logic [NUM_RD*AW-1:0]   rs_index;
  logic [NUM_RD*XLEN-1:0] rs_data;
  logic [NUM_RD-1:0]      rs_busy;
  logic                   issue_en;
  logic [AW-1:0]          issue_rd_index;
  logic                   issue_stall;
  logic                   flush;

  modport master (
    output wb_en, wb_index, wb_data, rs_index, issue_en, issue_rd_index, flush,
    input  rs_data, rs_busy, issue_stall
  );

  modport slave (
    input  wb_en, wb_index, wb_data, rs_index, issue_en, issue_rd_index, flush,
    output rs_data, rs_busy, issue_stall
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters with issue stall and read-port busy flags.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int unsigned NREG     = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter int unsigned PEND_W   = 2,
  localparam int unsigned AW      = idx_width(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_rd_index,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_index,
  input  logic                 flush,
  input  logic [NUM_RD*AW-1:0] rs_index,
  output logic [NUM_RD-1:0]    rs_busy,
  output logic                 issue_stall
);

  localparam logic [PEND_W-1:0] CntMax = '1;

  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]   inc;
  logic [NREG-1:0]   dec;
  logic              wb_ok;

  assign wb_ok = wb_en && !(ZERO_REG && wb_index == AW'(ZERO_IDX));

  // A retire to the saturated target frees a slot in the same cycle.
  assign issue_stall = issue_en && (cnt_q[issue_rd_index] == CntMax) &&
                       !(wb_en && wb_index == issue_rd_index);

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc[r] = issue_en && (issue_rd_index == AW'(r)) && !issue_stall &&
               !(ZERO_REG && r == ZERO_IDX);
      dec[r] = wb_en && (wb_index == AW'(r)) && (cnt_q[r] != '0);
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (inc[r] && !dec[r]) begin
        cnt_d[r] = cnt_q[r] + PEND_W'(1);
      end else if (dec[r] && !inc[r]) begin
        cnt_d[r] = cnt_q[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // A forwarded writeback satisfies the reader even while older writes are pending.
  always_comb begin
    rs_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rs_busy[k] = (cnt_q[rs_index[k*AW +: AW]] != '0) &&
                   !(BYPASS && wb_ok && wb_index == rs_index[k*AW +: AW]);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: async-clear storage, combinational read ports with optional
// writeback bypass, and a pending-write scoreboard for decode hazard checks.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter int unsigned PEND_W   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);

  localparam int unsigned AW = idx_width(NREG);

  logic [XLEN-1:0] regs_q  [NREG];
  logic [XLEN-1:0] rd_word [NUM_RD];
  logic            wb_ok;

  assign wb_ok = bus.wb_en && !(ZERO_REG && bus.wb_index == AW'(ZERO_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (wb_ok) begin
      regs_q[bus.wb_index] <= bus.wb_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = bus.rs_index[k*AW +: AW];

    always_comb begin
      if (ZERO_REG && idx == AW'(ZERO_IDX)) begin
        rd_word[k] = '0;
      end else if (BYPASS && wb_ok && bus.wb_index == idx) begin
        rd_word[k] = bus.wb_data;
      end else begin
        rd_word[k] = regs_q[idx];
      end
    end
  end

  always_comb begin
    bus.rs_data = '0;
    for (int k = 0; k < NUM_RD; k++) bus.rs_data[k*XLEN +: XLEN] = rd_word[k];
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .PEND_W   (PEND_W)
  ) u_scoreboard (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_en       (bus.issue_en),
    .issue_rd_index (bus.issue_rd_index),
    .wb_en          (bus.wb_en),
    .wb_index       (bus.wb_index),
    .flush          (bus.flush),
    .rs_index       (bus.rs_index),
    .rs_busy        (bus.rs_busy),
    .issue_stall    (bus.issue_stall)
  );

endmodule
